alu_result_queue: RTL and testbench
===================================

ALU_RESULT_QUEUE -- requirements
Module: alu_result_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 The block SHALL have parameter CNT_W, default 3, width of the occupancy count; equals log2(DEPTH)+1.
REQ-003 The block SHALL take data width `WIDTH and status bit indices `ST_CARRY, `ST_NEG, `ST_ZERO, `ST_OVERFLOW from ALU_inc.v.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 inValid  input  1  producer (ALU stage) offers a result this cycle.
REQ-007 inReady  output  1  queue can accept a word this cycle.
REQ-008 inResult  input  `WIDTH  ALU result word.
REQ-009 inStatus  input  4  ALU status flags accompanying inResult.
REQ-010 outValid  output  1  head entry present.
REQ-011 outReady  input  1  consumer takes head this cycle.
REQ-012 outResult  output  `WIDTH  head result word.
REQ-013 outStatus  output  4  head status flags.
REQ-014 stickyStatus  output  4  OR of status of every word accepted since last clear.
REQ-015 stickyClear  input  1  synchronous clear of stickyStatus and ovfCount.
REQ-016 ovfCount  output  8  saturating count of accepted words with overflow flag set.
REQ-017 count  output  CNT_W  current occupancy, 0..DEPTH.

Function
REQ-018 Push SHALL occur when inValid && inReady; pop SHALL occur when outValid && outReady.
REQ-019 inReady SHALL equal (count != DEPTH), a function of registered state only; no combinational path from outReady to inReady.
REQ-020 outValid SHALL equal (count != 0); outResult/outStatus SHALL present the head entry (first-word fall-through); they are don't-care when outValid=0.
REQ-021 A pushed word SHALL appear at the output no earlier than the cycle after the push (latency 1 into an empty queue).
REQ-022 Occupancy state SHALL be EMPTY (count=0), PARTIAL, or FULL (count=DEPTH); push-only increments, pop-only decrements, push+pop holds count.
REQ-023 Simultaneous push and pop SHALL be legal in PARTIAL; in EMPTY only push is possible; in FULL only pop is possible (inReady=0).
REQ-024 Write and read pointers SHALL wrap modulo DEPTH with no bubble at the wrap.
REQ-025 Words SHALL leave in acceptance order, unmodified in both result and status.
REQ-026 On push, stickyStatus SHALL become stickyStatus | inStatus at the next edge.
REQ-027 On push with inStatus[`ST_OVERFLOW]=1, ovfCount SHALL increment, saturating at 255.
REQ-028 stickyClear=1 SHALL set stickyStatus to 0 and ovfCount to 0, except that a same-cycle push loads stickyStatus=inStatus and ovfCount=inStatus[`ST_OVERFLOW].
REQ-029 Head entries and occupancy SHALL be unaffected by stickyClear.
REQ-030 inValid while inReady=0 SHALL have no effect; the producer holds the word.

Reset
REQ-031 While rst_n=0: count=0, pointers=0, outValid=0, inReady=0 is NOT required; inReady SHALL be 1 from the first edge after release.
REQ-032 Reset SHALL force stickyStatus=0, ovfCount=0 immediately, independent of clk.
REQ-033 Reset asserted mid-operation SHALL discard all queued entries; storage contents need not be cleared.

Structure
REQ-034 `WIDTH and `ST_* indices SHALL remain in ALU_inc.v; no new constants are added to it except a shared `ST_W (4) status-width define.
REQ-035 Storage and pointers SHALL sit in one sub-module, result_fifo_mem (DEPTH x (`WIDTH+4) register array, write port, async read port); flags and counters stay in the top.

Verification (bench `WIDTH=16, DEPTH=4)
REQ-036 Reset, then push 0x0005/status 0000 -> next cycle outValid=1, outResult=0x0005, count=1.
REQ-037 Push 4 words with outReady=0 -> count=4, inReady=0; fifth inValid ignored; pop all -> order preserved, count=0.
REQ-038 Hold count=2, push+pop every cycle for 10 cycles -> count stays 2, pointers wrap, data in order.
REQ-039 Push statuses 0001, 0100, 1000 (bit positions per `ST_*) -> stickyStatus=1101; stickyClear with push of overflow-set word -> stickyStatus equals that word's status, ovfCount=1.
REQ-040 Push 260 overflow-flagged words while draining -> ovfCount=255 and holds.
REQ-041 Fill to 3, assert rst_n=0 between edges -> count=0, outValid=0, stickyStatus=0 at once; first push after release is the head.

Source files
------------

// File: rtl/alu_result_queue_pkg.sv
// Types and constants shared by the ALU result queue and its storage sub-module.
`include "ALU_inc.v"

package alu_result_queue_pkg;

  localparam int DATA_W = `WIDTH;
  localparam int STAT_W = `ST_W;
  localparam int ST_OVF = `ST_OVERFLOW;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

endpackage

// File: rtl/ALU_inc.v
// Shared ALU constants: datapath width and status-flag bit positions.
`ifndef ALU_INC_V
`define ALU_INC_V

`define WIDTH       16
`define ST_CARRY    0
`define ST_ZERO     1
`define ST_NEG      2
`define ST_OVERFLOW 3
`define ST_W        4

`endif

// File: rtl/result_fifo_mem.sv
// Circular storage for queued ALU words: registered write port, async read of the head.
module result_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int DW    = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/alu_result_queue.sv
// First-word-fall-through queue for ALU results with sticky status and overflow counting.
module alu_result_queue
  import alu_result_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  // Handshake: a word moves when valid && ready at a rising edge; ready never depends on valid.
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] inResult,
  input  logic [STAT_W-1:0] inStatus,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outResult,
  output logic [STAT_W-1:0] outStatus,
  output logic [STAT_W-1:0] stickyStatus,
  input  logic              stickyClear,
  output logic [7:0]        ovfCount,
  output logic [CNT_W-1:0]  count,
  output occ_state_t        occ_state
);

  localparam int ENTRY_W = DATA_W + STAT_W;

  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  occ_state_t         state_q;
  occ_state_t         state_d;
  logic [ENTRY_W-1:0] head;

  // Ready/valid come from registered occupancy only, so outReady never reaches inReady.
  assign inReady   = (state_q != OCC_FULL);
  assign outValid  = (state_q != OCC_EMPTY);
  assign push      = inValid && inReady;
  assign pop       = outValid && outReady;
  assign count     = count_q;
  assign occ_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      state_q <= OCC_EMPTY;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (count_d == '0)                 state_d = OCC_EMPTY;
    else if (count_d == CNT_W'(DEPTH)) state_d = OCC_FULL;
    else                               state_d = OCC_PARTIAL;
  end

  // A clear coinciding with a push restarts accumulation from that word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stickyStatus <= '0;
      ovfCount     <= '0;
    end else if (stickyClear) begin
      stickyStatus <= push ? inStatus : '0;
      ovfCount     <= (push && inStatus[ST_OVF]) ? 8'd1 : 8'd0;
    end else if (push) begin
      stickyStatus <= stickyStatus | inStatus;
      if (inStatus[ST_OVF] && (ovfCount != 8'hFF)) ovfCount <= ovfCount + 8'd1;
    end
  end

  result_fifo_mem #(
    .DEPTH (DEPTH),
    .DW    (ENTRY_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data ({inStatus, inResult}),
    .rd_en   (pop),
    .rd_data (head)
  );

  assign {outStatus, outResult} = head;

endmodule

// File: tb/tb_alu_result_queue.sv
// Scoreboard bench for alu_result_queue: directed pushes, decoupled output monitor.
module tb_alu_result_queue;
  import alu_result_queue_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        inValid;
  logic        inReady;
  logic [15:0] inResult;
  logic [3:0]  inStatus;
  logic        outValid;
  logic        outReady;
  logic [15:0] outResult;
  logic [3:0]  outStatus;
  logic [3:0]  stickyStatus;
  logic        stickyClear;
  logic [7:0]  ovfCount;
  logic [2:0]  count;
  occ_state_t  occ_state;

  logic [19:0] exp_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  alu_result_queue #(.DEPTH(4), .CNT_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inValid      (inValid),
    .inReady      (inReady),
    .inResult     (inResult),
    .inStatus     (inStatus),
    .outValid     (outValid),
    .outReady     (outReady),
    .outResult    (outResult),
    .outStatus    (outStatus),
    .stickyStatus (stickyStatus),
    .stickyClear  (stickyClear),
    .ovfCount     (ovfCount),
    .count        (count),
    .occ_state    (occ_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // monitor: every word the consumer takes must be the oldest expected one
  always @(negedge clk) begin
    if (rst_n && outValid && outReady) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", {12'h0, outStatus, outResult}, 32'hFFFF_FFFF);
      end else begin
        check("pop_data", {12'h0, outStatus, outResult}, {12'h0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks: all called at posedge+1
  task automatic next_cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] r, input logic [3:0] s, input logic clr);
    int waited = 0;
    inValid = 1'b1;
    inResult = r;
    inStatus = s;
    stickyClear = clr;
    @(negedge clk);
    while (!inReady && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!inReady) check("push_timeout", 32'd0, 32'd1);
    else exp_q.push_back({s, r});
    @(posedge clk);
    #1;
    inValid = 1'b0;
    stickyClear = 1'b0;
  endtask

  task automatic drain();
    outReady = 1'b1;
    for (int i = 0; i < 20 && outValid; i++) next_cycle(1);
    outReady = 1'b0;
    check("drain_empty", {31'd0, outValid}, 32'd0);
    check("drain_queue", exp_q.size(), 32'd0);
  endtask

  task automatic clear_sticky();
    stickyClear = 1'b1;
    next_cycle(1);
    stickyClear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    inValid = 1'b0;
    inResult = '0;
    inStatus = '0;
    outReady = 1'b0;
    stickyClear = 1'b0;

    // reset state
    #12;
    check("rst_count", count, 32'd0);
    check("rst_outvalid", {31'd0, outValid}, 32'd0);
    check("rst_sticky", stickyStatus, 32'd0);
    check("rst_ovf", ovfCount, 32'd0);
    check("rst_state", occ_state, OCC_EMPTY);
    rst_n = 1'b1;
    next_cycle(1);
    check("post_rst_inready", {31'd0, inReady}, 32'd1);

    // single word, latency one
    push_word(16'h0005, 4'b0000, 1'b0);
    check("first_outvalid", {31'd0, outValid}, 32'd1);
    check("first_result", outResult, 32'h0005);
    check("first_count", count, 32'd1);
    drain();

    // fill to full, blocked fifth word, drain in order
    for (int i = 0; i < 4; i++) push_word(16'h1111 * (i + 1), 4'(i), 1'b0);
    check("full_count", count, 32'd4);
    check("full_inready", {31'd0, inReady}, 32'd0);
    check("full_state", occ_state, OCC_FULL);
    inValid = 1'b1;
    inResult = 16'hDEAD;
    next_cycle(2);
    inValid = 1'b0;
    check("blocked_count", count, 32'd4);
    drain();
    check("drained_count", count, 32'd0);

    // steady state at count 2 with push+pop every cycle across pointer wrap
    push_word(16'hA000, 4'b0000, 1'b0);
    push_word(16'hA001, 4'b0000, 1'b0);
    outReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_word(16'hB000 + 16'(i), 4'b0000, 1'b0);
      check("steady_count", count, 32'd2);
    end
    drain();

    // sticky accumulation, then clear with simultaneous overflow push
    clear_sticky();
    check("clr_sticky", stickyStatus, 32'd0);
    outReady = 1'b1;
    push_word(16'h0101, 4'b0001, 1'b0);
    push_word(16'h0102, 4'b0100, 1'b0);
    push_word(16'h0103, 4'b1000, 1'b0);
    check("sticky_or", stickyStatus, 32'b1101);
    check("sticky_ovf", ovfCount, 32'd1);
    push_word(16'h0104, 4'b1010, 1'b1);
    check("clr_push_sticky", stickyStatus, 32'b1010);
    check("clr_push_ovf", ovfCount, 32'd1);
    drain();

    // overflow count saturation
    clear_sticky();
    outReady = 1'b1;
    for (int i = 0; i < 260; i++) begin
      push_word(16'(i), 4'b1000, 1'b0);
      if (i == 99) check("ovf_100", ovfCount, 32'd100);
    end
    check("ovf_sat", ovfCount, 32'd255);
    push_word(16'h7777, 4'b1000, 1'b0);
    check("ovf_hold", ovfCount, 32'd255);
    drain();

    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) push_word(16'hC000 + 16'(i), 4'b0100, 1'b0);
    check("pre_rst_count", count, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_count", count, 32'd0);
    check("async_outvalid", {31'd0, outValid}, 32'd0);
    check("async_sticky", stickyStatus, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle(1);
    push_word(16'h00AB, 4'b0010, 1'b0);
    check("post_rst_head_valid", {31'd0, outValid}, 32'd1);
    check("post_rst_head", {12'h0, outStatus, outResult}, 32'h2_00AB);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
